// File: rtl/speed_ctrl_pkg.sv
// Shared definitions for the speed-control slice: FSM state encoding,
// default switch width and the mode code constants.
package speed_ctrl_pkg;

    localparam int SW_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        SETTLE    = 2'd2,
        COMMIT    = 2'd3
    } sw_state_e;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

endpackage

// File: rtl/sw_mode_debounce_if.sv
// Switch/mode bundle between the raw switch inputs and the debounced mode.
// Optional macro SW_GLITCH_COUNT_EN adds the glitch_cnt member.
interface sw_mode_debounce_if
    import speed_ctrl_pkg::*;
#(
    parameter int SW_W = SW_W_DEFAULT
) ();

    logic [SW_W-1:0] sw;
    logic            locked;
    logic [SW_W-1:0] mode;
    logic            mode_valid;
    logic            mode_chg;

`ifdef SW_GLITCH_COUNT_EN
    logic [7:0]      glitch_cnt;

    modport master (
        output sw,
        output locked,
        input  mode,
        input  mode_valid,
        input  mode_chg,
        input  glitch_cnt
    );

    modport slave (
        input  sw,
        input  locked,
        output mode,
        output mode_valid,
        output mode_chg,
        output glitch_cnt
    );
`else
    modport master (
        output sw,
        output locked,
        input  mode,
        input  mode_valid,
        input  mode_chg
    );

    modport slave (
        input  sw,
        input  locked,
        output mode,
        output mode_valid,
        output mode_chg
    );
`endif

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for asynchronous inputs. Every bit passes through
// DEPTH flops; reset clears the whole chain to zero.
module sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift the raw input into the bottom of the chain.
    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], din};
    end

    // Chain flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {(DEPTH*WIDTH){1'b0}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sw_mode_debounce.sv
// Switch conditioning for the speed-control top: synchronizes the mode
// switches and the clock lock, debounces the switches and publishes a
// committed mode code with a one-cycle change strobe. Mode is forced to
// stop while the clocks are unlocked.
// Optional macro SW_GLITCH_COUNT_EN adds a saturating count of settle
// restarts caused by switch bounce.
module sw_mode_debounce
    import speed_ctrl_pkg::*;
#(
    parameter int SW_W            = SW_W_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    sw_mode_debounce_if.slave bus
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sw_s;
    logic             locked_s;

    sw_state_e        state_q, state_d;
    logic [SW_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]  mode_q, mode_d;
    logic             mode_valid_q, mode_valid_d;
    logic             mode_chg_q, mode_chg_d;

    sync_chain #(
        .WIDTH (SW_W),
        .DEPTH (SYNC_STAGES)
    ) u_sw_sync (
        .clk  (clk_100mhz),
        .rst  (rst),
        .din  (bus.sw),
        .dout (sw_s)
    );

    sync_chain #(
        .WIDTH (1),
        .DEPTH (SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk_100mhz),
        .rst  (rst),
        .din  (bus.locked),
        .dout (locked_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cand_q       <= {SW_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            mode_q       <= {SW_W{1'b0}};
            mode_valid_q <= 1'b0;
            mode_chg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            mode_chg_q   <= mode_chg_d;
        end
    end

    // Next-state selection; loss of lock overrides every state.
    always_comb begin
        state_d = state_q;
        if (!locked_s) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: state_d = SETTLE;
                IDLE: begin
                    if (sw_s != mode_q) begin
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SETTLE: begin
                    if (sw_s != cand_q) begin
                        state_d = SETTLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = SETTLE;
                    end
                end
                COMMIT:  state_d = IDLE;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    // Candidate/counter/mode updates; outputs are computed here and registered.
    always_comb begin
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        mode_chg_d   = 1'b0;
        if (!locked_s) begin
            mode_d       = {SW_W{1'b0}};
            mode_valid_d = 1'b0;
            cnt_d        = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cand_d       = sw_s;
                    cnt_d        = {CNT_W{1'b0}};
                    mode_d       = {SW_W{1'b0}};
                    mode_valid_d = 1'b0;
                end
                IDLE: begin
                    if (sw_s != mode_q) begin
                        cand_d = sw_s;
                        cnt_d  = {CNT_W{1'b0}};
                    end else begin
                        cand_d = cand_q;
                    end
                end
                SETTLE: begin
                    if (sw_s != cand_q) begin
                        // Input moved before settling: restart on the new value.
                        cand_d = sw_s;
                        cnt_d  = {CNT_W{1'b0}};
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end
                COMMIT: begin
                    mode_d       = cand_q;
                    mode_valid_d = 1'b1;
                    mode_chg_d   = 1'b1;
                end
                default: begin
                    mode_d       = {SW_W{1'b0}};
                    mode_valid_d = 1'b0;
                    cnt_d        = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.mode       = mode_q;
    assign bus.mode_valid = mode_valid_q;
    assign bus.mode_chg   = mode_chg_q;

`ifdef SW_GLITCH_COUNT_EN
    logic       glitch_inc_s;
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // A restart in SETTLE caused by a switch change counts as one glitch.
    always_comb begin
        glitch_inc_s = locked_s && (state_q == SETTLE) && (sw_s != cand_q);
    end

    // Saturating increment of the glitch count.
    always_comb begin
        if (glitch_inc_s && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    // Glitch counter register; survives loss of lock, cleared only by reset.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            glitch_cnt_q <= 8'h00;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule
